eq_cmp_seq: RTL and testbench

Parametrised sequential comparator: it compares two WIDTH-bit operands CHUNK bits per cycle, starting at the most significant chunk. It produces one-hot equal, greater and less-than flags, with early termination at the first differing chunk. The block sits between operand-producing logic and any consumer that needs eq/gt/lt results. Valid/ready handshakes on both sides let it share a datapath with other multi-cycle units.

---
 rtl/eq_cmp_seq_pkg.sv | 21 ++
 rtl/eq_cmp_seq_if.sv | 34 +++
 rtl/eq_cmp_seq_chunk_cmp.sv | 33 +++
 rtl/eq_cmp_seq.sv | 136 +++++++++++++
 tb/tb_eq_cmp_seq.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/eq_cmp_seq_pkg.sv
// Shared definitions for the eq_cmp_seq sequential comparator.
//   state_t    : FSM state encoding (IDLE, CMP, DONE)
//   nchunk_of  : number of CHUNK-bit slices in a WIDTH-bit operand
//   cnt_width  : width of the nchk counter, able to hold 0..NCHUNK
package eq_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    function automatic int unsigned nchunk_of(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned chunk);
        return $clog2(nchunk_of(width, chunk)) + 1;
    endfunction

endpackage

// File: rtl/eq_cmp_seq_if.sv
// Handshake/bus bundle for eq_cmp_seq.
//   in_valid/in_ready/a/b           : operand request channel
//   out_valid/out_ready/eq/gt/lt/nchk : result channel
// Modports: master = operand producer and result consumer, slave = comparator.
interface eq_cmp_seq_if
    import eq_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
);
    localparam int unsigned NW = cnt_width(WIDTH, CHUNK);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             eq;
    logic             gt;
    logic             lt;
    logic [NW-1:0]    nchk;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, eq, gt, lt, nchk
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, eq, gt, lt, nchk
    );

endinterface

// File: rtl/eq_cmp_seq_chunk_cmp.sv
// Combinational CHUNK-bit magnitude compare of one operand slice.
//   x, y       : slices of the first and second operand
//   msb_signed : treat the slice's top bit as a two's-complement sign bit
//   ceq/cgt/clt: x == y, x > y, x < y (exactly one is high)
module chunk_cmp #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             msb_signed,
    output logic             ceq,
    output logic             cgt,
    output logic             clt
);

    logic [CHUNK-1:0] xs;
    logic [CHUNK-1:0] ys;

    // Flipping the sign bit on both sides maps two's-complement order
    // onto unsigned order, so one unsigned comparator serves both cases.
    always_comb begin
        xs = x;
        ys = y;
        if (msb_signed) begin
            xs[CHUNK-1] = ~x[CHUNK-1];
            ys[CHUNK-1] = ~y[CHUNK-1];
        end
        ceq = (xs == ys);
        cgt = (xs >  ys);
        clt = (xs <  ys);
    end

endmodule

// File: rtl/eq_cmp_seq.sv
// eq_cmp_seq: sequential comparator walking two WIDTH-bit operands CHUNK bits
// per cycle from the most significant slice, stopping at the first slice
// that differs. Produces one-hot eq/gt/lt plus the number of slices examined.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : eq_cmp_seq_if.slave (in_valid/in_ready/a/b, out_valid/out_ready/
//           eq/gt/lt/nchk)
// Build option: define EQCMP_SIGNED_EN to compare operands as two's
// complement (sign bit of the top slice inverted); otherwise unsigned.
module eq_cmp_seq
    import eq_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input logic         clk,
    input logic         reset,
    eq_cmp_seq_if.slave bus
);

    localparam int unsigned NCHUNK = nchunk_of(WIDTH, CHUNK);
    localparam int unsigned NW     = cnt_width(WIDTH, CHUNK);
    localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IW-1:0]    idx;
    logic [NW-1:0]    nchk_r;
    logic             out_valid_r;
    logic             eq_r;
    logic             gt_r;
    logic             lt_r;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic             msb_signed;
    logic             ceq;
    logic             cgt;
    logic             clt;

    // Slice mux written with constant part-selects so idx never indexes
    // past the operand.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (idx == IW'(i)) begin
                a_sl = a_r[i*CHUNK +: CHUNK];
                b_sl = b_r[i*CHUNK +: CHUNK];
            end
        end
    end

`ifdef EQCMP_SIGNED_EN
    assign msb_signed = (idx == IW'(NCHUNK - 1));
`else
    assign msb_signed = 1'b0;
`endif

    chunk_cmp #(
        .CHUNK(CHUNK)
    ) u_chunk_cmp (
        .x         (a_sl),
        .y         (b_sl),
        .msb_signed(msb_signed),
        .ceq       (ceq),
        .cgt       (cgt),
        .clt       (clt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            idx         <= '0;
            nchk_r      <= '0;
            out_valid_r <= 1'b0;
            eq_r        <= 1'b0;
            gt_r        <= 1'b0;
            lt_r        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        idx    <= IW'(NCHUNK - 1);
                        nchk_r <= '0;
                        eq_r   <= 1'b0;
                        gt_r   <= 1'b0;
                        lt_r   <= 1'b0;
                        state  <= CMP;
                    end
                end
                CMP: begin
                    nchk_r <= nchk_r + 1'b1;
                    if (!ceq) begin
                        gt_r        <= cgt;
                        lt_r        <= clt;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else if (idx == '0) begin
                        eq_r        <= 1'b1;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        eq_r        <= 1'b0;
                        gt_r        <= 1'b0;
                        lt_r        <= 1'b0;
                        nchk_r      <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // in_ready is gated by reset directly so it reads 0 while reset is held
    // and 1 as soon as reset drops, without waiting for another edge.
    assign bus.in_ready  = (state == IDLE) && !reset;
    assign bus.out_valid = out_valid_r;
    assign bus.eq        = eq_r;
    assign bus.gt        = gt_r;
    assign bus.lt        = lt_r;
    assign bus.nchk      = nchk_r;

endmodule

// File: tb/tb_eq_cmp_seq.sv
// Self-checking bench for eq_cmp_seq (WIDTH=32, CHUNK=8). Expected results
// come from a reference that works on whole 32-bit values: the first
// differing bit position gives the slice count, and plain integer
// comparison gives the ordering.
module tb_eq_cmp_seq;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    eq_cmp_seq_if #(.WIDTH(32), .CHUNK(8)) bus ();

    eq_cmp_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic e, output logic g, output logic l,
                                  output int k);
        logic [31:0] x;
        int p;
        x = a ^ b;
        p = -1;
        for (int i = 31; i >= 0; i--) begin
            if (p < 0 && x[i]) p = i;
        end
        if (p < 0) begin
            e = 1'b1; g = 1'b0; l = 1'b0; k = 4;
        end else begin
            e = 1'b0;
`ifdef EQCMP_SIGNED_EN
            g = ($signed(a) > $signed(b));
`else
            g = (a > b);
`endif
            l = !g;
            k = (31 - p) / 8 + 1;
        end
    endfunction

    // Present operands for one cycle; caller is at posedge+1 with in_ready high.
    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts edges from the accept edge until out_valid; bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.a = $urandom;
        bus.b = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready cyc %0d got %b want 0", i, bus.in_ready); end
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid cyc %0d got %b want 0", i, bus.out_valid); end
            checks++;
            if ({bus.eq, bus.gt, bus.lt} !== 3'b000) begin errors++; $display("FAIL reset_flags cyc %0d got %b want 000", i, {bus.eq, bus.gt, bus.lt}); end
            checks++;
            if (bus.nchk !== 3'd0) begin errors++; $display("FAIL reset_nchk cyc %0d got %0d want 0", i, bus.nchk); end
        end
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", bus.in_ready); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_no_accept out_valid %b in_ready %b want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_fixed(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic scramble);
        logic e, g, l;
        int k, cyc;
        model(a, b, e, g, l, k);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got %b want 1", name, bus.in_ready); end
        accept(a, b);
        if (scramble) begin
            // Operand changes after acceptance must not reach the result.
            cyc = 0;
            while (bus.out_valid !== 1'b1 && cyc < 20) begin
                bus.a = $urandom;
                bus.b = $urandom;
                bus.in_valid = 1'b1;
                @(posedge clk); #1;
                cyc++;
            end
            bus.in_valid = 1'b0;
        end else begin
            wait_done(cyc);
        end
        checks++;
        if (cyc !== k) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, cyc, k); end
        checks++;
        if ({bus.eq, bus.gt, bus.lt} !== {e, g, l}) begin
            errors++; $display("FAIL %s_flags eq/gt/lt got %b want %b", name, {bus.eq, bus.gt, bus.lt}, {e, g, l});
        end
        checks++;
        if (bus.nchk !== 3'(k)) begin errors++; $display("FAIL %s_nchk got %0d want %0d", name, bus.nchk, k); end
        release_result();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL %s_release out_valid %b in_ready %b want 0 1", name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        logic e, g, l;
        int k, cyc;
        a = $urandom;
        b = a ^ (32'h1 << $urandom_range(0, 31));
        model(a, b, e, g, l, k);
        accept(a, b);
        wait_done(cyc);
        checks++;
        if (cyc !== k) begin errors++; $display("FAIL bp_latency got %0d want %0d", cyc, k); end
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.a = $urandom;
            bus.b = $urandom;
            @(posedge clk); #1;
            checks++;
            if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
                errors++; $display("FAIL bp_hold_hs cyc %0d out_valid/in_ready got %b want 10", i, {bus.out_valid, bus.in_ready});
            end
            checks++;
            if ({bus.eq, bus.gt, bus.lt} !== {e, g, l} || bus.nchk !== 3'(k)) begin
                errors++; $display("FAIL bp_hold_res cyc %0d got %b/%0d want %b/%0d", i, {bus.eq, bus.gt, bus.lt}, bus.nchk, {e, g, l}, k);
            end
        end
        bus.in_valid = 1'b0;
        release_result();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release out_valid %b in_ready %b want 0 1", bus.out_valid, bus.in_ready);
        end
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_queue out_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_abort();
        int cyc;
        accept(32'h01020304, 32'h01020304);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.out_valid, bus.eq, bus.gt, bus.lt, bus.in_ready} !== 5'b00000 || bus.nchk !== 3'd0) begin
            errors++; $display("FAIL abort_state ov/eq/gt/lt/ir got %b nchk %0d want 00000 0",
                               {bus.out_valid, bus.eq, bus.gt, bus.lt, bus.in_ready}, bus.nchk);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_release_ready got %b want 1", bus.in_ready); end
        accept(32'd5, 32'd3);
        wait_done(cyc);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL abort_fresh_latency got %0d want 4", cyc); end
        checks++;
        if ({bus.eq, bus.gt, bus.lt} !== 3'b010 || bus.nchk !== 3'd4) begin
            errors++; $display("FAIL abort_fresh_result got %b/%0d want 010/4", {bus.eq, bus.gt, bus.lt}, bus.nchk);
        end
        release_result();
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic e, g, l;
        int k, cyc, hold;
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = $urandom;
                default: b = a ^ (32'($urandom) >> $urandom_range(0, 31));
            endcase
            model(a, b, e, g, l, k);
            accept(a, b);
            wait_done(cyc);
            hold = $urandom_range(0, 3);
            repeat (hold) begin @(posedge clk); #1; end
            checks++;
            if (cyc !== k) begin errors++; $display("FAIL rand_latency %0d a %h b %h got %0d want %0d", n, a, b, cyc, k); end
            checks++;
            if ({bus.eq, bus.gt, bus.lt} !== {e, g, l} || bus.nchk !== 3'(k)) begin
                errors++; $display("FAIL rand_result %0d a %h b %h got %b/%0d want %b/%0d", n, a, b,
                                   {bus.eq, bus.gt, bus.lt}, bus.nchk, {e, g, l}, k);
            end
            release_result();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        @(posedge clk); #1;
        test_reset();
        test_fixed("equal", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        test_fixed("msb", 32'h80000000, 32'h7FFFFFFF, 1'b0);
        test_fixed("lsb", 32'h12345678, 32'h12345679, 1'b1);
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
